// File: rtl/tinyml_pkg.sv
// Shared definitions for the tinyml datapath: ALU opcodes and the
// dot-product sequencer state encoding.
package tinyml_pkg;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_MAC4  = 4'b1000;
    localparam logic [3:0] OP_CONV3 = 4'b1101;
    localparam logic [3:0] OP_ACT   = 4'b1110;
    localparam logic [3:0] OP_PASS  = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_ACT  = 2'b10,
        ST_OUT  = 2'b11
    } seq_state_t;

    // Accumulation opcode for a job: CONV3 ignores lane 3, MAC4 uses all four.
    function automatic logic [3:0] dot_opcode(input logic conv);
        return conv ? OP_CONV3 : OP_MAC4;
    endfunction

endpackage

// File: rtl/dot_seq_ctrl.sv
// Dot-product sequencer: streams operand pairs through the shared int8 ALU,
// accumulates partial sums, optionally activates, and returns one result per job.
module dot_seq_ctrl
    import tinyml_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             mode,
    input  logic             act_en,
    output logic             busy,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [31:0]      op_a,
    input  logic [31:0]      op_b,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [3:0]       alu_op,
    input  logic [31:0]      alu_result,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data
);

    seq_state_t       state_reg, state_next;
    logic [LEN_W-1:0] len_reg, len_next;
    logic [LEN_W-1:0] cnt_reg, cnt_next;
    logic             mode_reg, mode_next;
    logic             act_en_reg, act_en_next;
    logic [31:0]      acc_reg, acc_next;
    logic [31:0]      res_data_reg, res_data_next;
    logic [31:0]      acc_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            len_reg      <= '0;
            cnt_reg      <= '0;
            mode_reg     <= 1'b0;
            act_en_reg   <= 1'b0;
            acc_reg      <= '0;
            res_data_reg <= '0;
        end else begin
            state_reg    <= state_next;
            len_reg      <= len_next;
            cnt_reg      <= cnt_next;
            mode_reg     <= mode_next;
            act_en_reg   <= act_en_next;
            acc_reg      <= acc_next;
            res_data_reg <= res_data_next;
        end
    end

    // Running sum including the pair presented this cycle; wraps at 32 bits.
    assign acc_sum = acc_reg + alu_result;

    always_comb begin
        state_next    = state_reg;
        len_next      = len_reg;
        cnt_next      = cnt_reg;
        mode_next     = mode_reg;
        act_en_next   = act_en_reg;
        acc_next      = acc_reg;
        res_data_next = res_data_reg;
        alu_a         = '0;
        alu_b         = '0;
        alu_op        = OP_ADD;
        op_ready      = 1'b0;
        res_valid     = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    len_next      = len;
                    mode_next     = mode;
                    act_en_next   = act_en;
                    acc_next      = '0;
                    cnt_next      = '0;
                    res_data_next = '0;
                    if (len != '0) begin
                        state_next = ST_RUN;
                    end else if (act_en) begin
                        state_next = ST_ACT;
                    end else begin
                        state_next = ST_OUT;
                    end
                end
            end

            ST_RUN: begin
                op_ready = 1'b1;
                alu_a    = op_a;
                alu_b    = op_b;
                alu_op   = dot_opcode(mode_reg);
                if (op_valid) begin
                    acc_next = acc_sum;
                    cnt_next = cnt_reg + LEN_W'(1);
                    if (cnt_reg == len_reg - LEN_W'(1)) begin
                        if (act_en_reg) begin
                            state_next = ST_ACT;
                        end else begin
                            res_data_next = acc_sum;
                            state_next    = ST_OUT;
                        end
                    end
                end
            end

            ST_ACT: begin
                alu_a         = acc_reg;
                alu_op        = OP_ACT;
                res_data_next = alu_result;
                state_next    = ST_OUT;
            end

            ST_OUT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign busy     = (state_reg != ST_IDLE);
    assign res_data = res_data_reg;

endmodule

// File: tb/tb_dot_seq_ctrl.sv
// Directed bench for dot_seq_ctrl; the shared ALU is modelled behaviourally here.
module tb_dot_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  len;
    logic        mode;
    logic        act_en;
    logic        busy;
    logic        op_valid;
    logic        op_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic [31:0] alu_result;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;

    int checks   = 0;
    int failures = 0;

    dot_seq_ctrl #(.LEN_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .len        (len),
        .mode       (mode),
        .act_en     (act_en),
        .busy       (busy),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        int s;
        logic signed [31:0] sh;
        s = 0;
        case (op)
            4'b1000, 4'b1101: begin
                for (int i = 0; i < 4; i++) begin
                    if (!(op == 4'b1101 && i == 3))
                        s += int'($signed(a[8*i +: 8])) * int'($signed(b[8*i +: 8]));
                end
                return s;
            end
            4'b1110: begin
                if ($signed(a) < -64) return 32'h0000_0080;
                if ($signed(a) > 64)  return 32'h0000_007F;
                sh = $signed(a) >>> 1;
                return {24'h0, sh[7:0]};
            end
            4'b0000: return a + b;
            default: return 32'h0;
        endcase
    endfunction

    assign alu_result = alu_model(alu_op, alu_a, alu_b);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // All tasks start and end right after a falling edge.
    task automatic start_job(input logic [7:0] l, input logic m, input logic a);
        check("idle_busy", {31'h0, busy}, 32'h0);
        start  = 1'b1;
        len    = l;
        mode   = m;
        act_en = a;
        @(negedge clk);
        start = 1'b0;
        check("busy_rise", {31'h0, busy}, 32'h1);
    endtask

    task automatic send_pair(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        op_valid = 1'b1;
        op_a     = a;
        op_b     = b;
        #1;
        check("run_op_ready", {31'h0, op_ready}, 32'h1);
        check("run_alu_op", {28'h0, alu_op}, {28'h0, op});
        check("run_alu_a", alu_a, a);
        @(negedge clk);
        op_valid = 1'b0;
    endtask

    task automatic expect_latency(input logic a, input logic [31:0] acc_exp);
        if (a) begin
            check("act_no_valid", {31'h0, res_valid}, 32'h0);
            check("act_alu_op", {28'h0, alu_op}, 32'he);
            check("act_alu_a", alu_a, acc_exp);
            @(negedge clk);
        end
        check("res_valid_latency", {31'h0, res_valid}, 32'h1);
    endtask

    task automatic get_result(input string tag, input logic [31:0] exp);
        int n;
        n = 0;
        while (!res_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, {31'h0, res_valid}, 32'h1);
        check({tag, "_data"}, res_data, exp);
        check({tag, "_idle_alu_op"}, {28'h0, alu_op}, 32'h0);
        $display("job %s result=0x%08h expected=0x%08h", tag, res_data, exp);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check({tag, "_busy_fall"}, {31'h0, busy}, 32'h0);
    endtask

    initial begin
        logic [31:0] held;
        rst_n = 1'b0; start = 1'b0; len = '0; mode = 1'b0; act_en = 1'b0;
        op_valid = 1'b0; op_a = '0; op_b = '0; res_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_op_ready", {31'h0, op_ready}, 32'h0);
        check("rst_res_valid", {31'h0, res_valid}, 32'h0);
        check("rst_res_data", res_data, 32'h0);
        check("rst_alu_op", {28'h0, alu_op}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // op_valid in IDLE must not be accepted
        op_valid = 1'b1;
        #1 check("idle_op_ready", {31'h0, op_ready}, 32'h0);
        @(negedge clk);
        op_valid = 1'b0;
        check("idle_stays_idle", {31'h0, busy}, 32'h0);

        // MAC4 len=2: 10 + (-8) = 2
        start_job(8'd2, 1'b0, 1'b0);
        send_pair(32'h01020304, 32'h01010101, 4'b1000);
        send_pair(32'hFFFFFFFF, 32'h02020202, 4'b1000);
        expect_latency(1'b0, 32'h0);
        get_result("mac4_len2", 32'h00000002);

        // CONV3 ignores lane 3
        start_job(8'd1, 1'b1, 1'b0);
        send_pair(32'h05010101, 32'h05010101, 4'b1101);
        expect_latency(1'b0, 32'h0);
        get_result("conv3", 32'h00000003);

        // Activation: clip high, shift positive, shift at -64 boundary
        start_job(8'd1, 1'b0, 1'b1);
        send_pair(32'h7F7F7F7F, 32'h7F7F7F7F, 4'b1000);
        expect_latency(1'b1, 32'd64516);
        get_result("act_clip", 32'h0000007F);

        start_job(8'd1, 1'b0, 1'b1);
        send_pair(32'h00000014, 32'h00000002, 4'b1000);
        expect_latency(1'b1, 32'd40);
        get_result("act_shift40", 32'h00000014);

        start_job(8'd1, 1'b0, 1'b1);
        send_pair(32'h000000C0, 32'h00000001, 4'b1000);
        expect_latency(1'b1, 32'hFFFFFFC0);
        get_result("act_neg64", 32'h000000E0);

        // len=0 with and without activation
        start_job(8'd0, 1'b0, 1'b1);
        expect_latency(1'b1, 32'h0);
        get_result("len0_act", 32'h00000000);

        start_job(8'd0, 1'b0, 1'b0);
        expect_latency(1'b0, 32'h0);
        get_result("len0_noact", 32'h00000000);

        // op_valid gaps 1,0,0,1; garbage operands and a stray start during gaps
        start_job(8'd2, 1'b0, 1'b0);
        send_pair(32'h01020304, 32'h01010101, 4'b1000);
        op_a = 32'h7F7F7F7F; op_b = 32'h7F7F7F7F;
        start = 1'b1; len = 8'd0;
        repeat (2) @(negedge clk);
        start = 1'b0;
        check("stall_busy", {31'h0, busy}, 32'h1);
        check("stall_no_valid", {31'h0, res_valid}, 32'h0);
        send_pair(32'h00000003, 32'h00000005, 4'b1000);
        expect_latency(1'b0, 32'h0);
        held = res_data;
        check("stall_sum", held, 32'h00000019);

        // Result back-pressure for 5 cycles; start is ignored meanwhile
        start = 1'b1; len = 8'd0; act_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", {31'h0, res_valid}, 32'h1);
            check("bp_data", res_data, held);
            check("bp_op_ready", {31'h0, op_ready}, 32'h0);
            check("bp_busy", {31'h0, busy}, 32'h1);
        end
        start = 1'b0;
        get_result("backpressure", 32'h00000019);
        @(negedge clk);
        check("bp_no_new_job", {31'h0, busy}, 32'h0);

        // Reset after 3 of 8 handshakes discards the job
        start_job(8'd8, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send_pair(32'h01010101, 32'h01010101, 4'b1000);
        op_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", {31'h0, busy}, 32'h0);
        check("mid_rst_op_ready", {31'h0, op_ready}, 32'h0);
        check("mid_rst_res_valid", {31'h0, res_valid}, 32'h0);
        check("mid_rst_alu_a", alu_a, 32'h0);
        check("mid_rst_alu_b", alu_b, 32'h0);
        check("mid_rst_alu_op", {28'h0, alu_op}, 32'h0);
        check("mid_rst_res_data", res_data, 32'h0);
        op_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_job(8'd1, 1'b0, 1'b0);
        send_pair(32'h02020202, 32'h03030303, 4'b1000);
        expect_latency(1'b0, 32'h0);
        get_result("after_reset", 32'h00000018);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
